// File: rtl/corelet_ctrl_if.sv
// corelet_ctrl_if: job request, L0 source handshake, OFIFO status and instruction bus of the corelet controller
interface corelet_ctrl_if #(
    parameter int cnt_bw = 8
);
    logic              start;
    logic              kernel_load;
    logic [cnt_bw-1:0] num_vec;
    logic              src_valid;
    logic              src_ready;
    logic              l0_full;
    logic              ofifo_valid;
    logic              ofifo_full;
    logic [33:0]       inst_q;
    logic              busy;
    logic              done;

    modport master (
        output start, kernel_load, num_vec, src_valid, l0_full, ofifo_valid, ofifo_full,
        input  src_ready, inst_q, busy, done
    );

    modport slave (
        input  start, kernel_load, num_vec, src_valid, l0_full, ofifo_valid, ofifo_full,
        output src_ready, inst_q, busy, done
    );
endinterface

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences kernel load, weight settle, activation write, execute and OFIFO drain for one job
module corelet_ctrl #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int cnt_bw = 8
) (
    input logic           clk,
    input logic           reset,
    corelet_ctrl_if.slave bus
);
    localparam int tw = $clog2(row + col + 1);
    localparam logic [cnt_bw-1:0] one = cnt_bw'(1);
    localparam logic [tw-1:0] tone = tw'(1);

    typedef enum logic [2:0] {IDLE, KWRITE, KLOAD, KSETTLE, XWRITE, EXEC, DRAIN, DONE} state_t;

    state_t            state;
    logic [cnt_bw-1:0] nv;
    logic [cnt_bw-1:0] wcnt;
    logic [cnt_bw-1:0] icnt;
    logic [cnt_bw-1:0] rcnt;
    logic [tw-1:0]     tmr;
    logic              wr_ph;
    logic              acc;
    logic              ld;
    logic              ex;
    logic              rd;

    // per-cycle command decode; reads stop once num_vec rows have been taken
    always_comb begin
        wr_ph = (state == KWRITE) || (state == XWRITE);
        acc   = wr_ph && !bus.l0_full && bus.src_valid;
        ld    = state == KLOAD;
        ex    = (state == EXEC) && !bus.ofifo_full;
        rd    = ((state == EXEC) || (state == DRAIN)) && bus.ofifo_valid && (rcnt != nv);
    end

    assign bus.src_ready = wr_ph && !bus.l0_full;
    assign bus.inst_q    = {27'b0, rd, 2'b0, ld | ex, acc, ex, ld};
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;

    // job state machine; counters compare against count+1 so num_vec of all ones never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            nv    <= '0;
            wcnt  <= '0;
            icnt  <= '0;
            rcnt  <= '0;
            tmr   <= '0;
        end else begin
            rcnt <= rcnt + cnt_bw'(rd);
            case (state)
                IDLE: if (bus.start && bus.num_vec != '0) begin
                    nv    <= bus.num_vec;
                    wcnt  <= '0;
                    icnt  <= '0;
                    rcnt  <= '0;
                    tmr   <= '0;
                    state <= bus.kernel_load ? KWRITE : XWRITE;
                end
                KWRITE: if (acc) begin
                    wcnt <= (wcnt == cnt_bw'(col - 1)) ? '0 : wcnt + one;
                    if (wcnt == cnt_bw'(col - 1)) state <= KLOAD;
                end
                KLOAD: begin
                    tmr <= (tmr == tw'(col - 1)) ? '0 : tmr + tone;
                    if (tmr == tw'(col - 1)) state <= KSETTLE;
                end
                KSETTLE: begin
                    tmr <= (tmr == tw'(row + col - 1)) ? '0 : tmr + tone;
                    if (tmr == tw'(row + col - 1)) state <= XWRITE;
                end
                XWRITE: if (acc) begin
                    wcnt <= wcnt + one;
                    if (wcnt + one == nv) state <= EXEC;
                end
                EXEC: if (ex) begin
                    icnt <= icnt + one;
                    if (icnt + one == nv) state <= DRAIN;
                end
                DRAIN: if (rcnt + cnt_bw'(rd) == nv) state <= DONE;
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: randomized and directed job scenarios checked against a phase-window model of the controller
module tb_corelet_ctrl;
    localparam int ROW = 8, COL = 8, BW = 8, MAXC = 4000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    corelet_ctrl_if #(.cnt_bw(BW)) bus ();
    corelet_ctrl #(.row(ROW), .col(COL), .cnt_bw(BW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit s_sv [MAXC], s_lf [MAXC], s_ov [MAXC], s_of [MAXC], s_st [MAXC], s_rst [MAXC];
    logic [33:0] r_iq [MAXC];
    logic r_rdy [MAXC], r_busy [MAXC], r_done [MAXC];
    int ncyc;
    int a_viol, a_kw, a_xw, a_ld, a_ex, a_rd, a_dn, a_done;
    int a_ld_last, a_xw_first, a_xw_last, a_ex_last, a_rd_last;

    task automatic fill(input int p_sv, input int p_lf, input int p_ov, input int p_of);
        for (int i = 0; i < MAXC; i++) begin
            s_sv[i] = $urandom_range(99) < p_sv;
            s_lf[i] = $urandom_range(99) < p_lf;
            s_ov[i] = $urandom_range(99) < p_ov;
            s_of[i] = $urandom_range(99) < p_of;
            s_st[i] = 1'b0;
            s_rst[i] = 1'b0;
        end
    endtask

    task automatic run(input bit kl, input logic [BW-1:0] nv, input int lim);
        int seen;
        seen = -1;
        ncyc = 0;
        for (int c = 0; c < lim && c < MAXC && (seen < 0 || c <= seen + 3); c++) begin
            @(negedge clk);
            reset = s_rst[c];
            bus.start = (c == 0) || s_st[c];
            bus.kernel_load = (c == 0) ? kl : 1'($urandom);
            bus.num_vec = (c == 0) ? nv : BW'($urandom);
            bus.src_valid = s_sv[c];
            bus.l0_full = s_lf[c];
            bus.ofifo_valid = s_ov[c];
            bus.ofifo_full = s_of[c];
            #1;
            r_iq[c] = bus.inst_q;
            r_rdy[c] = bus.src_ready;
            r_busy[c] = bus.busy;
            r_done[c] = bus.done;
            if (bus.done && seen < 0) seen = c;
            ncyc = c + 1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic analyze(input bit kl, input int nv);
        int kw_last, dmx;
        bit kwin, xwin, lwin, ewin, rwin, dexp;
        logic [33:0] iq;
        kw_last = -1;
        a_viol = 0; a_kw = 0; a_xw = 0; a_ld = 0; a_ex = 0; a_rd = 0; a_dn = 0; a_done = -1;
        a_ld_last = -1; a_xw_first = -1; a_xw_last = -1; a_ex_last = -1; a_rd_last = -1;
        for (int c = 0; c < ncyc; c++) begin
            iq = r_iq[c];
            kwin = kl && c >= 1 && a_kw < COL;
            xwin = (kl ? (a_ld_last >= 0 && c > a_ld_last + ROW + COL) : c >= 1) && a_xw < nv;
            lwin = kl && kw_last >= 0 && c > kw_last && c <= kw_last + COL;
            ewin = a_xw_last >= 0 && c > a_xw_last && a_ex < nv;
            rwin = a_xw_last >= 0 && c > a_xw_last && a_rd < nv;
            dmx = (a_ex_last + 2 > a_rd_last + 1) ? a_ex_last + 2 : a_rd_last + 1;
            dexp = a_ex == nv && a_rd == nv && c == dmx;
            if ((iq & ~34'h4F) != 0) a_viol++;
            if (r_rdy[c] !== ((kwin || xwin) && !s_lf[c])) a_viol++;
            if (iq[2] !== ((kwin || xwin) && !s_lf[c] && s_sv[c])) a_viol++;
            if (iq[0] !== lwin) a_viol++;
            if (iq[1] !== (ewin && !s_of[c])) a_viol++;
            if (iq[3] !== (lwin || (ewin && !s_of[c]))) a_viol++;
            if (iq[6] !== (rwin && s_ov[c])) a_viol++;
            if (a_done < 0 && (r_busy[c] !== (c > 0) || r_done[c] !== dexp)) a_viol++;
            if (a_done >= 0 && (r_busy[c] || r_rdy[c] || iq != 0 || r_done[c])) a_viol++;
            if (iq[2]) begin
                if (kwin) begin
                    a_kw++;
                    if (a_kw == COL) kw_last = c;
                end else begin
                    a_xw++;
                    if (a_xw_first < 0) a_xw_first = c;
                    if (a_xw == nv) a_xw_last = c;
                end
            end
            if (iq[0]) begin a_ld++; a_ld_last = c; end
            if (iq[1]) begin a_ex++; a_ex_last = c; end
            if (iq[6]) begin a_rd++; a_rd_last = c; end
            if (r_done[c]) begin a_dn++; if (a_done < 0) a_done = c; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 4) reset = 1'b0;
            bus.start = (i < 4);
            bus.kernel_load = 1'($urandom);
            bus.num_vec = BW'($urandom_range(255, 1));
            bus.src_valid = 1'b1;
            bus.l0_full = 1'b0;
            bus.ofifo_valid = 1'b1;
            bus.ofifo_full = 1'b0;
            #1;
            if ({bus.inst_q, bus.src_ready, bus.busy, bus.done} !== 37'd0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got inst=%h rdy=%b busy=%b done=%b exp all zero", i, bus.inst_q, bus.src_ready, bus.busy, bus.done);
            end
            checks++;
        end
    endtask

    task automatic test_kernel_job();
        fill(100, 0, 100, 0);
        run(1, 4, 200);
        analyze(1, 4);
        if (a_viol !== 0) begin failures++; $display("FAIL kjob_protocol got=%0d exp=0", a_viol); end
        checks++;
        if (a_kw !== 8 || a_ld !== 8 || a_ld_last !== 16) begin failures++; $display("FAIL kjob_load got kw=%0d ld=%0d last=%0d exp 8 8 16", a_kw, a_ld, a_ld_last); end
        checks++;
        if (a_xw_first !== 33 || a_xw !== 4) begin failures++; $display("FAIL kjob_settle got first=%0d xw=%0d exp 33 4", a_xw_first, a_xw); end
        checks++;
        if (a_ex !== 4 || a_rd !== 4) begin failures++; $display("FAIL kjob_exec got ex=%0d rd=%0d exp 4 4", a_ex, a_rd); end
        checks++;
        if (a_dn !== 1 || a_done !== 42) begin failures++; $display("FAIL kjob_done got n=%0d at=%0d exp 1 42", a_dn, a_done); end
        checks++;
    endtask

    task automatic test_l0_stall();
        fill(100, 0, 100, 0);
        s_lf[2] = 1'b1;
        s_lf[3] = 1'b1;
        run(0, 3, 100);
        analyze(0, 3);
        if (r_rdy[2] !== 1'b0 || r_rdy[3] !== 1'b0 || r_iq[2][2] !== 1'b0 || r_iq[3][2] !== 1'b0) begin
            failures++;
            $display("FAIL l0_stall got rdy=%b%b wr=%b%b exp 00 00", r_rdy[2], r_rdy[3], r_iq[2][2], r_iq[3][2]);
        end
        checks++;
        if (a_xw !== 3 || a_xw_last !== 5) begin failures++; $display("FAIL l0_writes got n=%0d last=%0d exp 3 5", a_xw, a_xw_last); end
        checks++;
        if (a_viol !== 0 || a_dn !== 1) begin failures++; $display("FAIL l0_job got viol=%0d done=%0d exp 0 1", a_viol, a_dn); end
        checks++;
    endtask

    task automatic test_exec_stall();
        fill(100, 0, 100, 0);
        s_of[7] = 1'b1;
        s_of[8] = 1'b1;
        run(0, 5, 100);
        analyze(0, 5);
        if (r_iq[7][1] !== 1'b0 || r_iq[8][1] !== 1'b0) begin failures++; $display("FAIL exec_stall got ex=%b%b exp 00", r_iq[7][1], r_iq[8][1]); end
        checks++;
        if (a_ex !== 5 || a_ex_last !== 12) begin failures++; $display("FAIL exec_count got n=%0d last=%0d exp 5 12", a_ex, a_ex_last); end
        checks++;
        if (a_viol !== 0 || a_done !== 14) begin failures++; $display("FAIL exec_job got viol=%0d done_at=%0d exp 0 14", a_viol, a_done); end
        checks++;
    endtask

    task automatic test_ignored_start();
        int nb, nd;
        fill(100, 0, 100, 0);
        run(1, 0, 6);
        nb = 0;
        nd = 0;
        for (int c = 0; c < ncyc; c++) begin
            nb += int'(r_busy[c]);
            nd += int'(r_done[c]);
        end
        if (nb !== 0 || nd !== 0) begin failures++; $display("FAIL zero_vec_start got busy=%0d done=%0d exp 0 0", nb, nd); end
        checks++;
        fill(100, 0, 100, 0);
        s_st[8] = 1'b1;
        s_st[9] = 1'b1;
        s_st[10] = 1'b1;
        s_st[14] = 1'b1;
        run(0, 6, 100);
        analyze(0, 6);
        if (a_viol !== 0 || a_ex !== 6) begin failures++; $display("FAIL busy_start got viol=%0d ex=%0d exp 0 6", a_viol, a_ex); end
        checks++;
        if (a_dn !== 1 || a_done !== 14 || r_busy[15] !== 1'b0) begin failures++; $display("FAIL busy_start_done got n=%0d at=%0d busy15=%b exp 1 14 0", a_dn, a_done, r_busy[15]); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int nd;
        fill(100, 0, 100, 0);
        s_rst[20] = 1'b1;
        run(1, 4, 40);
        nd = 0;
        for (int c = 0; c < ncyc; c++) nd += int'(r_done[c]);
        if (r_busy[20] !== 1'b1 || r_busy[21] !== 1'b0 || r_iq[21] !== 34'd0 || r_busy[39] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got busy20=%b busy21=%b inst21=%h busy39=%b exp 1 0 0 0", r_busy[20], r_busy[21], r_iq[21], r_busy[39]);
        end
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL reset_mid_done got=%0d exp=0", nd); end
        checks++;
        fill(100, 0, 100, 0);
        run(1, 4, 200);
        analyze(1, 4);
        if (a_viol !== 0 || a_dn !== 1 || a_done !== 42) begin failures++; $display("FAIL after_reset_job got viol=%0d n=%0d at=%0d exp 0 1 42", a_viol, a_dn, a_done); end
        checks++;
    endtask

    task automatic test_read_limit();
        fill(100, 0, 100, 0);
        run(0, 2, 100);
        analyze(0, 2);
        if (a_rd !== 2) begin failures++; $display("FAIL read_limit got=%0d exp=2", a_rd); end
        checks++;
        if (a_viol !== 0 || a_dn !== 1 || a_done !== 6) begin failures++; $display("FAIL read_limit_done got viol=%0d n=%0d at=%0d exp 0 1 6", a_viol, a_dn, a_done); end
        checks++;
    endtask

    task automatic test_random();
        bit kl;
        int nv, dexp;
        for (int j = 0; j < 8; j++) begin
            kl = 1'($urandom_range(1));
            nv = $urandom_range(24, 1);
            fill($urandom_range(100, 40), $urandom_range(40), $urandom_range(100, 30), $urandom_range(40));
            run(kl, BW'(nv), 3000);
            analyze(kl, nv);
            dexp = (a_ex_last + 2 > a_rd_last + 1) ? a_ex_last + 2 : a_rd_last + 1;
            if (a_viol !== 0 || a_dn !== 1) begin failures++; $display("FAIL rand_protocol job=%0d got viol=%0d done=%0d exp 0 1", j, a_viol, a_dn); end
            checks++;
            if (a_kw !== (kl ? COL : 0) || a_ld !== (kl ? COL : 0) || a_xw !== nv) begin
                failures++;
                $display("FAIL rand_writes job=%0d got kw=%0d ld=%0d xw=%0d exp %0d %0d %0d", j, a_kw, a_ld, a_xw, kl ? COL : 0, kl ? COL : 0, nv);
            end
            checks++;
            if (a_ex !== nv || a_rd !== nv || a_done !== dexp) begin
                failures++;
                $display("FAIL rand_exec job=%0d got ex=%0d rd=%0d at=%0d exp %0d %0d %0d", j, a_ex, a_rd, a_done, nv, nv, dexp);
            end
            checks++;
        end
    endtask

    task automatic test_max_count();
        fill(90, 15, 70, 15);
        run(0, 8'd255, 3000);
        analyze(0, 255);
        if (a_xw !== 255 || a_ex !== 255 || a_rd !== 255) begin failures++; $display("FAIL max_count got xw=%0d ex=%0d rd=%0d exp 255 255 255", a_xw, a_ex, a_rd); end
        checks++;
        if (a_viol !== 0 || a_dn !== 1) begin failures++; $display("FAIL max_done got viol=%0d n=%0d exp 0 1", a_viol, a_dn); end
        checks++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.kernel_load = 1'b0;
        bus.num_vec = '0;
        bus.src_valid = 1'b0;
        bus.l0_full = 1'b0;
        bus.ofifo_valid = 1'b0;
        bus.ofifo_full = 1'b0;
        test_reset();
        test_kernel_job();
        test_l0_stall();
        test_exec_stall();
        test_ignored_start();
        test_reset_mid();
        test_read_limit();
        test_random();
        test_max_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
